// File: rtl/adc_frame_buffer.sv
// rtl/adc_frame_buffer.sv - ping-pong ADC frame buffer serving samples to the FFT core
// Capture fills one bank while the FFT core reads the other; adc_flag marks a held frame.
module adc_frame_buffer #(
  parameter int DATA_W     = 12,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int DECIM      = 1,
  parameter int OFFSET_BIN = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic              updata_flag,
  output logic [DATA_W-1:0] mix_signal,
  output logic              adc_flag,
  output logic              overrun
);

  localparam int                CNT_W     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DECIM - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] CONV_MASK = (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  typedef enum logic {C_FILL, C_STALL} cap_state_t;
  typedef enum logic {R_IDLE, R_HOLD}  rd_state_t;

  cap_state_t c_state, c_next;
  rd_state_t  r_state, r_next;

  logic [DATA_W-1:0] mem [0:2*DEPTH-1];
  logic [1:0]        full, full_rel, full_nxt;
  logic              wr_bank, rd_bank, pick_bank;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  decim_cnt;
  logic              accept, last_wr, other_free, release_bank;
  logic              wr_en, complete, swap, drop, present;

  assign accept       = adc_valid && (decim_cnt == CNT_LAST);
  assign last_wr      = (wr_ptr == PTR_LAST);
  assign release_bank = (r_state == R_HOLD) && updata_flag;

  // A release in this cycle is already visible to capture, so a completing bank never stalls on it
  assign full_rel   = full & ~(release_bank ? (2'b01 << rd_bank) : 2'b00);
  assign other_free = !full_rel[~wr_bank];
  assign full_nxt   = full_rel | (complete ? (2'b01 << wr_bank) : 2'b00);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) c_state <= C_FILL;
    else          c_state <= c_next;
  end

  always_comb begin
    c_next = c_state;
    case (c_state)
      C_FILL:  if (accept && last_wr && !other_free) c_next = C_STALL;
      C_STALL: if (other_free) c_next = C_FILL;
      default: c_next = C_FILL;
    endcase
  end

  always_comb begin
    wr_en    = 1'b0;
    complete = 1'b0;
    swap     = 1'b0;
    drop     = 1'b0;
    case (c_state)
      C_FILL: begin
        wr_en    = accept;
        complete = accept && last_wr;
        swap     = accept && last_wr && other_free;
      end
      C_STALL: begin
        drop = accept;
        swap = other_free;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (full != 2'b00) r_next = R_HOLD;
      R_HOLD:  if (updata_flag) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // With both banks full, ~rd_bank is the older frame
  always_comb begin
    present   = (r_state == R_IDLE) && (full != 2'b00);
    pick_bank = full[~rd_bank] ? ~rd_bank : rd_bank;
    adc_flag  = (r_state == R_HOLD);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      decim_cnt  <= '0;
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      wr_ptr     <= '0;
      rd_bank    <= 1'b0;
      overrun    <= 1'b0;
      mix_signal <= '0;
    end else begin
      if (adc_valid) decim_cnt <= accept ? '0 : decim_cnt + 1'b1;
      full <= full_nxt;
      if (wr_en)   wr_ptr  <= wr_ptr + 1'b1;
      if (swap)    wr_bank <= ~wr_bank;
      if (present) rd_bank <= pick_bank;
      if (drop)    overrun <= 1'b1;
      mix_signal <= mem[{rd_bank, address}] ^ CONV_MASK;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[{wr_bank, wr_ptr}] <= adc_data;
  end

endmodule

// File: tb/tb_adc_frame_buffer.sv
// tb/tb_adc_frame_buffer.sv - frame-queue model plus directed vectors for adc_frame_buffer
// Instance 0: DECIM=1, offset binary; instance 1: DECIM=4, pass-through. Both DEPTH=16.
module tb_adc_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] data  [2];
  logic        valid [2];
  logic [3:0]  addr  [2];
  logic        upd   [2];
  logic [11:0] mix   [2];
  logic        flag  [2];
  logic        ovr   [2];

  always #10 clk = ~clk;

  adc_frame_buffer #(.DATA_W(12), .DEPTH(16), .ADDR_W(4), .DECIM(1), .OFFSET_BIN(1)) u_a (
    .sys_clk(clk), .sys_rst(rst_n), .adc_data(data[0]), .adc_valid(valid[0]),
    .address(addr[0]), .updata_flag(upd[0]), .mix_signal(mix[0]),
    .adc_flag(flag[0]), .overrun(ovr[0]));

  adc_frame_buffer #(.DATA_W(12), .DEPTH(16), .ADDR_W(4), .DECIM(4), .OFFSET_BIN(0)) u_b (
    .sys_clk(clk), .sys_rst(rst_n), .adc_data(data[1]), .adc_valid(valid[1]),
    .address(addr[1]), .updata_flag(upd[1]), .mix_signal(mix[1]),
    .adc_flag(flag[1]), .overrun(ovr[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: FIFO of completed frames (head = presented one) plus the frame being assembled
  int          n_str [2];
  int          rcnt  [2];
  int          plen  [2];
  bit          m_flag[2];
  bit          m_ovr [2];
  bit          chk_mix[2];
  logic [11:0] exp_mix[2];
  logic [11:0] rf [2][2][16];
  logic [11:0] pf [2][16];

  function automatic logic [11:0] conv(int i, logic [11:0] d);
    return (i == 0) ? (d ^ 12'h800) : d;
  endfunction

  function automatic int decim_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic mstep(int i);
    bit pre_flag;
    int pre_r;
    if (!rst_n) begin
      n_str[i] = 0; rcnt[i] = 0; plen[i] = 0;
      m_flag[i] = 1'b0; m_ovr[i] = 1'b0;
      exp_mix[i] = 12'h000; chk_mix[i] = 1'b1;
      return;
    end
    pre_flag = m_flag[i];
    pre_r    = rcnt[i];
    if (pre_flag) exp_mix[i] = conv(i, rf[i][0][addr[i]]);
    if (pre_flag && upd[i]) begin
      for (int k = 0; k < 16; k++) rf[i][0][k] = rf[i][1][k];
      rcnt[i]--;
      m_flag[i] = 1'b0;
    end else if (!pre_flag && pre_r > 0) begin
      m_flag[i] = 1'b1;
    end
    chk_mix[i] = pre_flag && m_flag[i];
    if (valid[i]) begin
      n_str[i]++;
      if (n_str[i] % decim_of(i) == 0) begin
        if (pre_r == 2) m_ovr[i] = 1'b1;
        else begin
          pf[i][plen[i]] = data[i];
          plen[i]++;
          if (plen[i] == 16) begin
            for (int k = 0; k < 16; k++) rf[i][rcnt[i]][k] = pf[i][k];
            rcnt[i]++;
            plen[i] = 0;
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      mstep(0);
      mstep(1);
      #1;
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cyc_flag%0d", i), 32'(flag[i]), 32'(m_flag[i]));
        check($sformatf("cyc_ovr%0d", i), 32'(ovr[i]), 32'(m_ovr[i]));
        if (chk_mix[i]) check($sformatf("cyc_mix%0d", i), 32'(mix[i]), 32'(exp_mix[i]));
      end
    end
  end

  task automatic push(int i, logic [11:0] d);
    valid[i] = 1'b1; data[i] = d;
    @(negedge clk);
    valid[i] = 1'b0;
  endtask

  task automatic push_rel(int i, logic [11:0] d);
    valid[i] = 1'b1; data[i] = d; upd[i] = 1'b1;
    @(negedge clk);
    valid[i] = 1'b0; upd[i] = 1'b0;
  endtask

  task automatic release_pulse(int i);
    upd[i] = 1'b1;
    @(negedge clk);
    upd[i] = 1'b0;
  endtask

  task automatic rd(int i, logic [3:0] a, logic [11:0] exp, string name);
    addr[i] = a;
    @(negedge clk);
    check(name, 32'(mix[i]), 32'(exp));
  endtask

  function automatic logic [11:0] frame2(int n);
    int j;
    j = n - 17;
    if (n > 32) return 12'(12'h500 + n);
    if (j == 0) return 12'h000;
    if (j == 1) return 12'hFFF;
    if (j == 2) return 12'h800;
    return 12'(12'h100 + j);
  endfunction

  initial begin
    logic [11:0] d;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data[i] = '0; valid[i] = 1'b0; addr[i] = '0; upd[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_flag%0d", i), 32'(flag[i]), 32'd0);
      check($sformatf("rst_mix%0d", i), 32'(mix[i]), 32'd0);
      check($sformatf("rst_ovr%0d", i), 32'(ovr[i]), 32'd0);
    end
    for (int k = 0; k < 4; k++) push(0, 12'(12'h800 + k));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_flag_idle", 32'(flag[0]), 32'd0);

    for (int k = 0; k < 16; k++) push(0, 12'(12'h800 + k));
    check("t2_flag_pre", 32'(flag[0]), 32'd0);
    @(negedge clk);
    check("t2_flag_rise", 32'(flag[0]), 32'd1);
    rd(0, 4'd5, 12'h005, "t2_mix5");
    rd(0, 4'd0, 12'h000, "t2_mix0");

    for (int n = 17; n <= 40; n++) begin
      push(0, frame2(n));
      if (n == 32) check("t4_ovr_before", 32'(ovr[0]), 32'd0);
      if (n == 33) check("t4_ovr_set", 32'(ovr[0]), 32'd1);
    end
    check("t4_flag_held", 32'(flag[0]), 32'd1);
    push_rel(0, 12'hEEE);
    check("t4_gap", 32'(flag[0]), 32'd0);
    @(negedge clk);
    check("t4_rise", 32'(flag[0]), 32'd1);
    rd(0, 4'd0, 12'h800, "t3_conv_000");
    rd(0, 4'd1, 12'h7FF, "t3_conv_fff");
    rd(0, 4'd2, 12'h000, "t3_conv_800");
    rd(0, 4'd9, 12'h909, "t4_sample26");

    for (int k = 0; k < 15; k++) push(0, 12'(12'h300 + k));
    push_rel(0, 12'h30F);
    check("sim_gap", 32'(flag[0]), 32'd0);
    @(negedge clk);
    check("sim_rise", 32'(flag[0]), 32'd1);
    rd(0, 4'd15, 12'hB0F, "sim_mix15");
    check("sim_ovr_sticky", 32'(ovr[0]), 32'd1);
    for (int k = 0; k < 16; k++) push(0, 12'(12'h400 + k));
    release_pulse(0);
    check("nostall_gap", 32'(flag[0]), 32'd0);
    @(negedge clk);
    check("nostall_rise", 32'(flag[0]), 32'd1);
    rd(0, 4'd0, 12'hC00, "nostall_mix0");

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_rst_mix", 32'(mix[0]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rst_flag", 32'(flag[0]), 32'd0);
    check("t6_rst_ovr", 32'(ovr[0]), 32'd0);
    release_pulse(0);
    for (int k = 0; k < 7; k++) push(0, 12'(12'h600 + k));
    release_pulse(0);
    check("t6_ignored_upd", 32'(flag[0]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) push(0, 12'(12'h700 + k));
    repeat (2) @(negedge clk);
    check("t6_flag_15", 32'(flag[0]), 32'd0);
    push(0, 12'h70F);
    check("t6_flag_16_pre", 32'(flag[0]), 32'd0);
    @(negedge clk);
    check("t6_flag_rise", 32'(flag[0]), 32'd1);
    rd(0, 4'd7, 12'hF07, "t6_mix7");

    for (int k = 0; k < 64; k++) push(1, 12'(k));
    check("t5_flag_pre", 32'(flag[1]), 32'd0);
    @(negedge clk);
    check("t5_flag_rise", 32'(flag[1]), 32'd1);
    rd(1, 4'd0, 12'd3, "t5_mix0");
    rd(1, 4'd5, 12'd23, "t5_mix5");
    rd(1, 4'd15, 12'd63, "t5_mix15");
    release_pulse(1);
    check("t5_released", 32'(flag[1]), 32'd0);
    for (int k = 0; k < 64; k++) begin
      if (k % 4 != 3)  d = 12'hAAA;
      else if (k == 3) d = 12'h000;
      else if (k == 7) d = 12'hFFF;
      else if (k == 11) d = 12'h800;
      else             d = 12'(k);
      push(1, d);
    end
    @(negedge clk);
    check("t3b_flag", 32'(flag[1]), 32'd1);
    rd(1, 4'd0, 12'h000, "t3b_pass_000");
    rd(1, 4'd1, 12'hFFF, "t3b_pass_fff");
    rd(1, 4'd2, 12'h800, "t3b_pass_800");
    check("t5_no_ovr", 32'(ovr[1]), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_frame_buffer.md
Name: adc_frame_buffer

Overview:
- Producer side of the ADC-to-FFT sample interface: captures ADC samples into a two-bank (ping-pong) RAM and announces a complete frame with adc_flag.
- Serves samples to the FFT core by address (address in, mix_signal out), and frees the bank when the FFT core pulses updata_flag.
- Sits between the ADC front-end capture and FFT_CT, all in the sys_clk (50 MHz) domain.

Parameters:
DATA_W, 12, ADC sample width
DEPTH, 1024, samples per frame (power of two)
ADDR_W, 10, log2(DEPTH)
DECIM, 1, keep every DECIM-th adc_valid strobe (1 = keep all)
OFFSET_BIN, 1, 1 = ADC delivers offset binary, convert to two's complement on output; 0 = pass through

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst  input  1  asynchronous reset, active-low
adc_data  input  DATA_W  raw ADC sample
adc_valid  input  1  one-cycle sample strobe
address  input  ADDR_W  read address from the FFT core
updata_flag  input  1  one-cycle release pulse from the FFT core
mix_signal  output  DATA_W  sample read at address, registered
adc_flag  output  1  level-high while a complete frame is held for reading
overrun  output  1  sticky: samples were dropped because both banks were busy

Behaviour:
- Interface: one clock (sys_clk); reset sys_rst is asynchronous and active-low.
- Reset: adc_flag=0, mix_signal=0, overrun=0, full[1:0]=0, wr_bank=0, wr_ptr=0, rd_bank=0, decim_cnt=0, capture FSM in C_FILL, read FSM in R_IDLE.
- Reset mid-frame discards all data. No frame is presented until DEPTH new samples are captured.
- Decimation: decim_cnt counts adc_valid strobes from 0 to DECIM-1. A sample is accepted when adc_valid=1 and decim_cnt==DECIM-1; decim_cnt then wraps to 0. With DECIM=1, every strobe is accepted.
- Capture FSM:
  - C_FILL: an accepted sample is written to bank[wr_bank][wr_ptr] and wr_ptr increments.
  - On a write with wr_ptr==DEPTH-1: full[wr_bank]<=1 and wr_ptr<=0. If full[~wr_bank]==0, wr_bank<=~wr_bank and the FSM stays in C_FILL. Otherwise it goes to C_STALL.
  - C_STALL: accepted samples are dropped and overrun<=1 (sticky until reset). When full[~wr_bank] clears, wr_bank<=~wr_bank, wr_ptr=0, and the FSM returns to C_FILL. decim_cnt keeps counting during the stall.
- Read FSM:
  - R_IDLE: if any full bank exists, rd_bank<=that bank (prefer ~rd_bank if both are full), adc_flag<=1, and the FSM goes to R_HOLD. adc_flag rises 1 cycle after the edge that set full.
  - R_HOLD: on updata_flag=1, full[rd_bank]<=0 and adc_flag<=0, and the FSM goes to R_IDLE. adc_flag is therefore low for at least 1 cycle between frames; each rising edge marks a new frame.
  - updata_flag while adc_flag=0 is ignored.
- Read port: mix_signal<=conv(bank[rd_bank][address]) every cycle, 1-cycle latency. The value is valid only while adc_flag=1.
- conv: if OFFSET_BIN=1, invert the MSB; otherwise pass through unchanged.
- The write and read banks never coincide while adc_flag=1 (the held bank is full and cannot be written).
- Simultaneous events:
  - Release and bank completion in the same cycle: the release clears full first. Capture then sees the freed bank and continues without stalling. The newly full bank is presented after the 1-cycle low gap.
  - adc_valid on the cycle capture leaves C_STALL: the sample is dropped. Writing starts on the next accepted sample.

Test Plan:
1. Reset with DEPTH=16, DECIM=1; hold sys_rst=0 for 3 cycles → all outputs 0. adc_valid strobes without sys_rst release → nothing captured.
2. Feed ramp 0x800..0x80F (16 strobes) → adc_flag=1 one cycle after the 16th write. address=5 → mix_signal=0x005 the next cycle. address=0 → 0x000.
3. OFFSET_BIN check: sample 0x000 → 0x800 (−2048); 0xFFF → 0x7FF; 0x800 → 0x000. With OFFSET_BIN=0, all three pass unchanged.
4. Ping-pong: keep feeding 40 samples with no release → bank 1 fills, capture stalls, overrun=1, samples 33..40 dropped. Pulse updata_flag → adc_flag low exactly 1 cycle, then high. The reads return samples 17..32. Capture restarts at bank 0, ptr 0.
5. DECIM=4: 64 strobes with data = strobe index → frame holds indices 3, 7, …, 63. adc_flag rises after the 64th strobe.
6. updata_flag pulsed while adc_flag=0 → no state change. Assert sys_rst mid-frame (after 7 samples) → after release, 16 fresh samples are required before adc_flag rises.
